inst_mem_rom: RTL and testbench
===============================

// Module: inst_mem_rom
// PURPOSE
//  Read-only RV32I instruction memory for the single-cycle/pipelined core fetch stage.
//  Maps a byte PC to a 32-bit instruction word through a combinational (zero-latency) read.
//  Pre-loaded with a fixed test program; unprogrammed words read as NOP (addi x0,x0,0).
//  Illegal fetches (misaligned or out of range) return NOP and raise fault flags.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words (4 KB byte space, 0x000-0xFFF)
//  NOP_INSTR    32'h00000013  word returned for empty, misaligned or out-of-range fetches
// PORTS
//  clk               in   1   system clock; only the sticky fault register uses it
//  reset             in   1   asynchronous, active-low reset
//  PC                in   32  byte address of the instruction to fetch
//  Instruction_Code  out  32  instruction word at PC (combinational)
//  misaligned        out  1   PC[1:0] != 2'b00 (combinational)
//  out_of_range      out  1   PC >= DEPTH_WORDS*4 (combinational)
//  fault_sticky      out  1   latched OR of misaligned|out_of_range
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Read path purely combinational: Instruction_Code follows PC in the same delta cycle,
//    independent of clk and reset (valid even while reset is low or undriven).
//  - word_addr = PC[31:2]. Priority: misaligned -> NOP_INSTR; else out_of_range -> NOP_INSTR;
//    else mem[word_addr].
//  - out_of_range compares the full 32-bit PC (PC=0x1000 -> word 1024 -> illegal).
//  - Contents fixed at elaboration; no write port. Pre-loaded program (word: hex, asm):
//    0:0x00801083 lh x1,8(x0)    1:0x00101623 sh x1,12(x0)   2:0x402081B3 sub x3,x1,x2
//    3:0x0020E233 or x4,x1,x2    4:0x0050F293 andi x5,x1,5   5:0x0020D333 srl x6,x1,x2
//    6:0x00510463 beq x2,x5,+8   7..DEPTH_WORDS-1: NOP_INSTR
//  - misaligned and out_of_range are combinational from PC; both may be high at once.
//  - fault_sticky: reset low -> 0 immediately (async). On each rising clk edge with reset
//    high, fault_sticky <= fault_sticky | misaligned | out_of_range. Cleared only by reset.
//  - No X propagation: PC containing X/Z -> output unspecified but not required checked.
// TESTING
//  - PC=0x00000000 -> Instruction_Code=0x00801083, misaligned=0, out_of_range=0.
//  - PC=0x00000018 -> Instruction_Code=0x00510463; PC=0x00000004 -> 0x00101623.
//  - PC=0x00000100 (unprogrammed word 64) -> 0x00000013, no flags.
//  - PC=0x00000005 -> 0x00000013, misaligned=1; PC=0x00001000 -> 0x00000013, out_of_range=1;
//    PC=0x00000FFC -> 0x00000013, out_of_range=0.
//  - Reset low then high, drive PC=0x00000005 across one clk edge -> fault_sticky=1;
//    return PC=0x0 -> stays 1; pulse reset low mid-cycle -> fault_sticky=0 without clk edge.
//  - Change PC with clk stopped and reset low -> Instruction_Code still tracks PC.

Source files
------------

// File: rtl/inst_mem_rom.sv
// Read-only RV32I instruction memory: combinational fetch of a fixed program, plus
// misaligned/out-of-range detection and a sticky fault flag that only reset clears.
module inst_mem_rom #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] Instruction_Code,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        fault_sticky
);

  // One extra bit so the byte limit never wraps, whatever DEPTH_WORDS is.
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [29:0] word_addr;
  logic [31:0] rom_word;

  assign word_addr    = PC[31:2];
  assign misaligned   = (PC[1:0] != 2'b00);
  assign out_of_range = ({1'b0, PC} >= BYTE_LIMIT);

  // NOTE: rom_word is given a default before the case so no path leaves it unassigned,
  // which keeps this block purely combinational instead of inferring a latch.
  always_comb begin
    rom_word = NOP_INSTR;
    case (word_addr)
      30'd0:   rom_word = 32'h0080_1083; // lh   x1, 8(x0)
      30'd1:   rom_word = 32'h0010_1623; // sh   x1, 12(x0)
      30'd2:   rom_word = 32'h4020_81B3; // sub  x3, x1, x2
      30'd3:   rom_word = 32'h0020_E233; // or   x4, x1, x2
      30'd4:   rom_word = 32'h0050_F293; // andi x5, x1, 5
      30'd5:   rom_word = 32'h0020_D333; // srl  x6, x1, x2
      30'd6:   rom_word = 32'h0051_0463; // beq  x2, x5, +8
      default: rom_word = NOP_INSTR;
    endcase
  end

  // Illegal fetches must never leak program words into the pipeline.
  assign Instruction_Code = (misaligned || out_of_range) ? NOP_INSTR : rom_word;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_sticky <= 1'b0;
    end else if (misaligned || out_of_range) begin
      fault_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_mem_rom.sv
// Directed self-checking bench for inst_mem_rom: fetch contents, fault flags and the
// sticky fault register, with hand-computed expected values.
module tb_inst_mem_rom;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Instruction_Code;
  logic        misaligned;
  logic        out_of_range;
  logic        fault_sticky;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    logic        oor;
  } vec_t;

  vec_t vecs[$];

  inst_mem_rom dut (
    .clk              (clk),
    .reset            (reset),
    .PC               (PC),
    .Instruction_Code (Instruction_Code),
    .misaligned       (misaligned),
    .out_of_range     (out_of_range),
    .fault_sticky     (fault_sticky)
  );

  // Gated clock so the bench can stop it for the clock-free checks.
  always #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    clk_en   = 1'b0;
    reset    = 1'b0;
    PC       = 32'h0;

    vecs.push_back('{32'h0000_0000, 32'h0080_1083, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0004, 32'h0010_1623, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0008, 32'h4020_81B3, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_000C, 32'h0020_E233, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0010, 32'h0050_F293, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0014, 32'h0020_D333, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0018, 32'h0051_0463, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_001C, NOP,           1'b0, 1'b0});
    vecs.push_back('{32'h0000_0100, NOP,           1'b0, 1'b0});
    vecs.push_back('{32'h0000_0005, NOP,           1'b1, 1'b0});
    vecs.push_back('{32'h0000_0002, NOP,           1'b1, 1'b0});
    vecs.push_back('{32'h0000_0FFC, NOP,           1'b0, 1'b0});
    vecs.push_back('{32'h0000_1000, NOP,           1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, NOP,           1'b0, 1'b1});
    vecs.push_back('{32'h4000_0004, NOP,           1'b0, 1'b1});
    vecs.push_back('{32'h0000_1006, NOP,           1'b1, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, NOP,           1'b1, 1'b1});

    // Reset held low, clock stopped: flag cleared, fetch path still live.
    #1;
    check("sticky_in_reset", 32'(fault_sticky), 32'h0);
    foreach (vecs[i]) begin
      PC = vecs[i].pc;
      #1;
      check($sformatf("instr@%08h", vecs[i].pc), Instruction_Code, vecs[i].instr);
      check($sformatf("mis@%08h", vecs[i].pc), 32'(misaligned), 32'(vecs[i].mis));
      check($sformatf("oor@%08h", vecs[i].pc), 32'(out_of_range), 32'(vecs[i].oor));
    end
    check("sticky_no_clk", 32'(fault_sticky), 32'h0);

    // Release reset with a legal PC and run the clock.
    PC = 32'h0;
    #1;
    reset  = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("sticky_legal_run", 32'(fault_sticky), 32'h0);

    @(negedge clk);
    PC = 32'h0000_0005;
    @(posedge clk);
    #1;
    check("sticky_set_mis", 32'(fault_sticky), 32'h1);

    @(negedge clk);
    PC = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("sticky_holds", 32'(fault_sticky), 32'h1);
    check("instr_after_fault", Instruction_Code, 32'h0080_1083);

    // Asynchronous clear mid-cycle, well before the next rising edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("sticky_async_clr", 32'(fault_sticky), 32'h0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("sticky_stays_clr", 32'(fault_sticky), 32'h0);

    // Out-of-range alone also sets the flag.
    @(negedge clk);
    PC = 32'h0000_1000;
    @(posedge clk);
    #1;
    check("sticky_set_oor", 32'(fault_sticky), 32'h1);

    @(negedge clk);
    PC = 32'h0000_0FFC;
    reset = 1'b0;
    #1;
    check("sticky_clr2", 32'(fault_sticky), 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("sticky_last_word", 32'(fault_sticky), 32'h0);

    clk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
